sim_err_monitor: RTL and testbench

Parametrised N-channel error-event monitor for the Verilator top level, generalising the fixed nine-channel CHERI-error reporter. It converts level or modulated error lines into single events, which it reports through a valid/ready port to the DPI consumer. It also keeps sticky flags, saturating per-channel counts, first-occurrence timestamps and dropped-event flags, and supports first-only and report-all modes.

---
 rtl/sim_err_monitor.sv | 182 ++++++++++++++++++
 tb/tb_sim_err_monitor.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sim_err_monitor.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | sim_err_monitor                                                             |
// | N-channel error-event monitor: edge-detects raw error lines, keeps sticky,  |
// | count and drop flags, and reports events through a valid/ready port.       |
// | Optional: SIM_ERR_MON_TIMESTAMP_EN adds a cycle counter and timestamps.     |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+

module sim_err_monitor #(
  parameter int unsigned NumChan   = 9,
  parameter int unsigned CntW      = 16,
  parameter int unsigned TsW       = 48,
  parameter bit          ReportAll = 1'b0,
  parameter int unsigned ChW       = (NumChan > 1) ? $clog2(NumChan) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NumChan-1:0]      err_i,
  input  logic                    clear_i,
  output logic                    ev_valid_o,
  input  logic                    ev_ready_i,
  output logic [ChW-1:0]          ev_chan_o,
  output logic [TsW-1:0]          ev_time_o,
  output logic                    ev_first_o,
  output logic [NumChan-1:0]      errored_o,
  output logic [NumChan*CntW-1:0] count_o,
  output logic [NumChan-1:0]      drop_o
);

  logic [NumChan-1:0]      err_q;
  logic [NumChan-1:0]      errored_q, errored_d;
  logic [NumChan-1:0]      drop_q, drop_d;
  logic [NumChan-1:0]      pend_q, pend_d;
  logic [NumChan-1:0]      pfirst_q, pfirst_d;
  logic [NumChan*CntW-1:0] count_q, count_d;
  logic                    valid_q, valid_d;
  logic [ChW-1:0]          chan_q, chan_d;
  logic                    first_q, first_d;

  logic [NumChan-1:0]      rise;
  logic [NumChan-1:0]      load_oh;
  logic                    free;
  logic                    sel_vld;
  logic [ChW-1:0]          sel_idx;
  logic                    load;

`ifdef SIM_ERR_MON_TIMESTAMP_EN
  logic [TsW-1:0]          cyc_q;
  logic [TsW-1:0]          ts_q [NumChan];
  logic [TsW-1:0]          ts_d [NumChan];
  logic [TsW-1:0]          time_q, time_d;
`endif

  always_comb begin
    rise    = err_i & ~err_q;
    free    = ~valid_q | ev_ready_i;
    sel_vld = 1'b0;
    sel_idx = '0;
    // Descending scan so the lowest pending index is the one left standing.
    for (int c = int'(NumChan) - 1; c >= 0; c--) begin
      if (pend_q[c]) begin
        sel_vld = 1'b1;
        sel_idx = ChW'(c);
      end
    end
    load = free & sel_vld & ~clear_i;
    for (int c = 0; c < int'(NumChan); c++) begin
      load_oh[c] = load & (sel_idx == ChW'(c));
    end
  end

  always_comb begin
    valid_d = valid_q;
    chan_d  = chan_q;
    first_d = first_q;
`ifdef SIM_ERR_MON_TIMESTAMP_EN
    time_d  = time_q;
`endif
    if (free) begin
      valid_d = load;
      if (load) begin
        chan_d  = sel_idx;
        first_d = pfirst_q[sel_idx];
`ifdef SIM_ERR_MON_TIMESTAMP_EN
        time_d  = ts_q[sel_idx];
`endif
      end
    end
  end

  always_comb begin
    count_d   = count_q;
    errored_d = errored_q;
    drop_d    = drop_q;
    pend_d    = pend_q & ~load_oh;
    pfirst_d  = pfirst_q;
`ifdef SIM_ERR_MON_TIMESTAMP_EN
    ts_d      = ts_q;
`endif
    for (int c = 0; c < int'(NumChan); c++) begin
      if (rise[c]) begin
        if (count_q[c*CntW +: CntW] != {CntW{1'b1}}) begin
          count_d[c*CntW +: CntW] = count_q[c*CntW +: CntW] + CntW'(1);
        end
        errored_d[c] = 1'b1;
        if (ReportAll || !errored_q[c]) begin
          // A channel being loaded this cycle frees its slot for the new rise.
          if (pend_q[c] && !load_oh[c]) begin
            drop_d[c] = 1'b1;
          end else begin
            pend_d[c]   = 1'b1;
            pfirst_d[c] = ~errored_q[c];
`ifdef SIM_ERR_MON_TIMESTAMP_EN
            ts_d[c]     = cyc_q;
`endif
          end
        end
      end
    end
    if (clear_i) begin
      count_d   = '0;
      errored_d = '0;
      drop_d    = '0;
      pend_d    = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q     <= '0;
      errored_q <= '0;
      drop_q    <= '0;
      pend_q    <= '0;
      pfirst_q  <= '0;
      count_q   <= '0;
      valid_q   <= 1'b0;
      chan_q    <= '0;
      first_q   <= 1'b0;
    end else begin
      err_q     <= err_i;
      errored_q <= errored_d;
      drop_q    <= drop_d;
      pend_q    <= pend_d;
      pfirst_q  <= pfirst_d;
      count_q   <= count_d;
      valid_q   <= valid_d;
      chan_q    <= chan_d;
      first_q   <= first_d;
    end
  end

`ifdef SIM_ERR_MON_TIMESTAMP_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cyc_q  <= '0;
      time_q <= '0;
      for (int c = 0; c < int'(NumChan); c++) begin
        ts_q[c] <= '0;
      end
    end else begin
      cyc_q  <= cyc_q + TsW'(1);
      time_q <= time_d;
      ts_q   <= ts_d;
    end
  end

  assign ev_time_o = time_q;
`else
  assign ev_time_o = {TsW{1'b0}};
`endif

  assign ev_valid_o = valid_q;
  assign ev_chan_o  = chan_q;
  assign ev_first_o = first_q;
  assign errored_o  = errored_q;
  assign count_o    = count_q;
  assign drop_o     = drop_q;

endmodule

`default_nettype wire

// File: tb/tb_sim_err_monitor.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_sim_err_monitor                                                          |
// | Two monitor instances (first-only / report-all with 2-bit counts) share one |
// | stimulus and are compared every cycle against an event-level model.         |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+

module tb_sim_err_monitor;

  localparam int NC = 9;

  logic          clk;
  logic          rst_n;
  logic [NC-1:0] err;
  logic          clear;
  logic          ready;

  logic          v0, v1;
  logic [3:0]    ch0, ch1;
  logic [47:0]   t0, t1;
  logic          f0, f1;
  logic [NC-1:0] er0, er1, dr0, dr1;
  logic [NC*16-1:0] cnt0;
  logic [NC*2-1:0]  cnt1;

  sim_err_monitor #(.NumChan(9), .CntW(16), .TsW(48), .ReportAll(1'b0)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .err_i(err), .clear_i(clear),
    .ev_valid_o(v0), .ev_ready_i(ready), .ev_chan_o(ch0), .ev_time_o(t0),
    .ev_first_o(f0), .errored_o(er0), .count_o(cnt0), .drop_o(dr0)
  );

  sim_err_monitor #(.NumChan(9), .CntW(2), .TsW(48), .ReportAll(1'b1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .err_i(err), .clear_i(clear),
    .ev_valid_o(v1), .ev_ready_i(ready), .ev_chan_o(ch1), .ev_time_o(t1),
    .ev_first_o(f1), .errored_o(er1), .count_o(cnt1), .drop_o(dr1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit     RA   [2] = '{1'b0, 1'b1};
  int     CMAX [2] = '{65535, 3};
  int     CW   [2] = '{16, 2};

  int     m_cnt  [2][NC];
  bit     m_err  [2][NC];
  bit     m_drop [2][NC];
  bit     m_pend [2][NC];
  longint m_pts  [2][NC];
  bit     m_pf   [2][NC];
  bit     h_v [2];
  int     h_ch[2];
  longint h_t [2];
  bit     h_f [2];
  bit     eprev[NC];
  longint mcyc;

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int c = 0; c < NC; c++) begin
        m_cnt[m][c] = 0; m_err[m][c] = 0; m_drop[m][c] = 0;
        m_pend[m][c] = 0; m_pts[m][c] = 0; m_pf[m][c] = 0;
      end
      h_v[m] = 0; h_ch[m] = 0; h_t[m] = 0; h_f[m] = 0;
    end
    for (int c = 0; c < NC; c++) eprev[c] = 0;
    mcyc = 0;
  endtask

  task automatic model_step();
    bit rise[NC];
    for (int c = 0; c < NC; c++) rise[c] = err[c] && !eprev[c];
    for (int m = 0; m < 2; m++) begin
      int ld;
      ld = -1;
      if (!h_v[m] || ready) begin
        h_v[m] = 0;
        if (!clear)
          for (int c = 0; c < NC; c++)
            if (ld < 0 && m_pend[m][c]) ld = c;
        if (ld >= 0) begin
          h_v[m] = 1; h_ch[m] = ld; h_t[m] = m_pts[m][ld]; h_f[m] = m_pf[m][ld];
          m_pend[m][ld] = 0;
        end
      end
      if (clear) begin
        for (int c = 0; c < NC; c++) begin
          m_cnt[m][c] = 0; m_err[m][c] = 0; m_drop[m][c] = 0; m_pend[m][c] = 0;
        end
      end else begin
        for (int c = 0; c < NC; c++) begin
          if (rise[c]) begin
            bit was;
            was = m_err[m][c];
            if (m_cnt[m][c] < CMAX[m]) m_cnt[m][c]++;
            m_err[m][c] = 1;
            if (RA[m] || !was) begin
              if (m_pend[m][c]) m_drop[m][c] = 1;
              else begin
                m_pend[m][c] = 1; m_pts[m][c] = mcyc; m_pf[m][c] = !was;
              end
            end
          end
        end
      end
    end
    for (int c = 0; c < NC; c++) eprev[c] = err[c];
    mcyc++;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  task automatic cmp_inst(input int m, input logic v, input logic [3:0] ch,
                          input logic [47:0] t, input logic f, input logic [NC-1:0] er,
                          input logic [NC-1:0] dr, input logic [NC*16-1:0] cnt);
    logic [NC-1:0] e_er, e_dr;
    logic [63:0]   et;
    for (int c = 0; c < NC; c++) begin
      e_er[c] = m_err[m][c];
      e_dr[c] = m_drop[m][c];
    end
    chk($sformatf("u%0d valid @%0d", m, mcyc), {63'd0, v}, {63'd0, h_v[m]});
    if (h_v[m] && v) begin
`ifdef SIM_ERR_MON_TIMESTAMP_EN
      et = 64'(h_t[m]);
`else
      et = 64'd0;
`endif
      chk($sformatf("u%0d chan @%0d", m, mcyc), {60'd0, ch}, 64'(h_ch[m]));
      chk($sformatf("u%0d time @%0d", m, mcyc), {16'd0, t}, et);
      chk($sformatf("u%0d first @%0d", m, mcyc), {63'd0, f}, {63'd0, h_f[m]});
    end
    chk($sformatf("u%0d errored @%0d", m, mcyc), 64'(er), 64'(e_er));
    chk($sformatf("u%0d drop @%0d", m, mcyc), 64'(dr), 64'(e_dr));
    for (int c = 0; c < NC; c++)
      chk($sformatf("u%0d count[%0d] @%0d", m, c, mcyc),
          64'((cnt >> (c * CW[m])) & (NC*16)'(CMAX[m])), 64'(m_cnt[m][c]));
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst_n) begin
        cmp_inst(0, v0, ch0, t0, f0, er0, dr0, cnt0);
        cmp_inst(1, v1, ch1, t1, f1, er1, dr1, {{(NC*14){1'b0}}, cnt1});
      end
    end
  end

  // ---------------- accepted-record log ----------------
  typedef struct { int ch; longint t; bit f; int pe; } rec_t;
  rec_t log0[$];
  rec_t log1[$];
  int   pe = 0;

  initial begin
    forever begin
      @(posedge clk);
      pe++;
      if (rst_n && v0 && ready) log0.push_back('{int'(ch0), longint'(t0), f0, pe});
      if (rst_n && v1 && ready) log1.push_back('{int'(ch1), longint'(t1), f1, pe});
    end
  end

  // ---------------- stimulus ----------------
  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; err = '0; clear = 1'b0;
    #1;
    chk("reset valid0", {63'd0, v0}, 64'd0);
    chk("reset chan0", {60'd0, ch0}, 64'd0);
    chk("reset time0", {16'd0, t0}, 64'd0);
    chk("reset first0", {63'd0, f0}, 64'd0);
    chk("reset errored0", 64'(er0), 64'd0);
    chk("reset count0 nonzero", {63'd0, |cnt0}, 64'd0);
    chk("reset drop0", 64'(dr0), 64'd0);
    chk("reset dut1 any", {63'd0, v1 | (|ch1) | (|t1) | f1 | (|er1) | (|cnt1) | (|dr1)}, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    log0.delete();
    log1.delete();
  endtask

  task automatic pulse(input int c);
    @(negedge clk); err[c] = 1'b1;
    @(negedge clk); err[c] = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; err = '0; clear = 1'b0; ready = 1'b0;

    // Single pulse on channel 3 at counter value 100.
    ready = 1'b1;
    apply_reset();
    for (int i = 0; i < 200 && mcyc != 100; i++) @(negedge clk);
    chk("counter reaches 100", 64'(mcyc), 64'd100);
    err[3] = 1'b1;
    @(negedge clk); err[3] = 1'b0;
    repeat (5) @(negedge clk);
    chk("t1 records", 64'(log0.size()), 64'd1);
    if (log0.size() >= 1) begin
      chk("t1 chan", 64'(log0[0].ch), 64'd3);
      chk("t1 first", {63'd0, log0[0].f}, 64'd1);
`ifdef SIM_ERR_MON_TIMESTAMP_EN
      chk("t1 time", 64'(log0[0].t), 64'd100);
`else
      chk("t1 time", 64'(log0[0].t), 64'd0);
`endif
    end
    chk("t1 errored", 64'(er0), 64'h008);
    chk("t1 count3", 64'(cnt0[3*16 +: 16]), 64'd1);

    // Toggling channel 0 with a 4-cycle period.
    apply_reset();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); err[0] = (i % 4) < 2;
    end
    @(negedge clk); err[0] = 1'b0;
    repeat (4) @(negedge clk);
    chk("t2 records", 64'(log0.size()), 64'd1);
    chk("t2 count0", 64'(cnt0[15:0]), 64'd10);
    chk("t2 drop", 64'(dr0), 64'd0);
    chk("t2 ra count0 saturated", 64'(cnt1[1:0]), 64'd3);

    // Simultaneous rises on 0, 5, 8 with ready held low.
    ready = 1'b0;
    apply_reset();
    @(negedge clk); err = 9'h121;
    @(negedge clk); err = '0;
    repeat (10) @(negedge clk);
    #1;
    chk("t3 held valid", {63'd0, v1}, 64'd1);
    chk("t3 held chan", {60'd0, ch1}, 64'd0);
    ready = 1'b1;
    repeat (6) @(negedge clk);
    chk("t3 records", 64'(log1.size()), 64'd3);
    if (log1.size() >= 3) begin
      chk("t3 order", 64'({log1[0].ch[3:0], log1[1].ch[3:0], log1[2].ch[3:0]}), 64'h058);
      chk("t3 firsts", 64'({log1[0].f, log1[1].f, log1[2].f}), 64'h7);
      chk("t3 back-to-back", 64'({log1[1].pe - log1[0].pe, log1[2].pe - log1[1].pe}), {32'd1, 32'd1});
    end

    // Three rises on channel 2 while ready is low.
    ready = 1'b0;
    apply_reset();
    pulse(2); pulse(2); pulse(2);
    repeat (3) @(negedge clk);
    chk("t4 drop2", 64'(dr1), 64'h004);
    ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("t4 records", 64'(log1.size()), 64'd2);
    if (log1.size() >= 2) chk("t4 second first", {63'd0, log1[1].f}, 64'd0);

    // Five rises on channel 1.
    apply_reset();
    for (int i = 0; i < 5; i++) pulse(1);
    repeat (3) @(negedge clk);
    chk("t5 sat count1", 64'(cnt1[3:2]), 64'd3);
    chk("t5 wide count1", 64'(cnt0[16 +: 16]), 64'd5);

    // Clear collides with a rise on channel 4 while a record is held.
    ready = 1'b0;
    apply_reset();
    pulse(6);
    repeat (2) @(negedge clk);
    err[4] = 1'b1; clear = 1'b1;
    @(negedge clk); clear = 1'b0; err[4] = 1'b0;
    #1;
    chk("t6 count zero", {62'd0, |cnt0, |cnt1}, 64'd0);
    chk("t6 errored zero", 64'({er0, er1}), 64'd0);
    chk("t6 drop zero", 64'({dr0, dr1}), 64'd0);
    chk("t6 held chan", {59'd0, v0, ch0}, 64'h16);
    ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("t6 records", 64'({log0.size(), log1.size()}), {32'd1, 32'd1});
    if (log0.size() >= 1) chk("t6 chan", 64'(log0[0].ch), 64'd6);

    // Randomized traffic with one mid-run reset.
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (i == 1500) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
      for (int c = 0; c < NC; c++)
        if ($urandom_range(0, 5) == 0) err[c] = ~err[c];
      ready = (i % 200 < 60) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
      clear = ($urandom_range(0, 99) == 0);
    end
    @(negedge clk);
    err = '0; clear = 1'b0; ready = 1'b1;
    repeat (20) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
